cpu6_ifu_fetch: RTL and testbench

Instruction fetch stage of the cpu6 pipeline, sitting directly upstream of decode and the ID/EX pipeline register. It owns the PC and issues in-order requests to instruction memory. Returned instructions are buffered in a small FIFO whose head is the registered IF/ID output to decode. It absorbs decode stalls and EX-stage redirects (taken branch/jump), and discards stale in-flight responses after a redirect.

---
 rtl/cpu6_ifu_fetch.sv | 84 ++++++++
 tb/tb_cpu6_ifu_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cpu6_ifu_fetch.sv
// cpu6_ifu_fetch: PC owner issuing in-order imem requests into an IF/ID instruction FIFO
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
module cpu6_ifu_fetch #(
  parameter logic [`CPU6_XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [`CPU6_XLEN-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  input  logic                  redirect,
  input  logic [`CPU6_XLEN-1:0] redirect_pc,
  input  logic                  stallD,
  output logic                  validD,
  output logic [31:0]           instrD,
  output logic [`CPU6_XLEN-1:0] pcD
);
  localparam int XL = `CPU6_XLEN;
  localparam int CW = $clog2(DEPTH + 1);
  logic [XL-1:0] pc_q, pc_d;
  logic [CW-1:0] os_q, os_d, dc_q, dc_d, cnt_q, cnt_d, wr, tw;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];
  logic [XL-1:0] fpc_q [DEPTH];
  logic [XL-1:0] fpc_d [DEPTH];
  logic [XL-1:0] tag_q [DEPTH];
  logic [XL-1:0] tag_d [DEPTH];
  logic          cons, rv, hs, push;
  logic [CW:0]   occ;
  assign validD    = cnt_q != '0;
  assign instrD    = ins_q[0];
  assign pcD       = fpc_q[0];
  assign imem_addr = pc_q;
  // next state: entry 0 of both shift queues is the head, so decode sees flops directly
  always_comb begin
    cons     = validD & ~stallD & ~redirect;
    rv       = imem_rvalid & (os_q != '0);
    occ      = {1'b0, os_q} + {1'b0, cnt_q} - (CW+1)'(cons);
    imem_req = ~reset & ~redirect & (occ < (CW+1)'(DEPTH));
    hs       = imem_req & imem_ready;
    push     = rv & (dc_q == '0) & ~redirect;
    wr       = cnt_q - CW'(cons);
    tw       = os_q - CW'(rv);
    pc_d     = redirect ? redirect_pc : hs ? pc_q + XL'(4) : pc_q;
    os_d     = os_q + CW'(hs) - CW'(rv);
    dc_d     = redirect ? os_q - CW'(rv) : dc_q - CW'(rv & (dc_q != '0));
    cnt_d    = redirect ? '0 : cnt_q + CW'(push) - CW'(cons);
    for (int i = 0; i < DEPTH; i++) begin
      ins_d[i] = (push && wr == CW'(i)) ? imem_rdata :
                 (cons && i < DEPTH - 1) ? ins_q[(i + 1) % DEPTH] : ins_q[i];
      fpc_d[i] = (push && wr == CW'(i)) ? tag_q[0] :
                 (cons && i < DEPTH - 1) ? fpc_q[(i + 1) % DEPTH] : fpc_q[i];
      tag_d[i] = (hs && tw == CW'(i)) ? pc_q :
                 (rv && i < DEPTH - 1) ? tag_q[(i + 1) % DEPTH] : tag_q[i];
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      os_q  <= '0;
      dc_q  <= '0;
      cnt_q <= '0;
      ins_q <= '{default: '0};
      fpc_q <= '{default: '0};
      tag_q <= '{default: '0};
    end else begin
      pc_q  <= pc_d;
      os_q  <= os_d;
      dc_q  <= dc_d;
      cnt_q <= cnt_d;
      ins_q <= ins_d;
      fpc_q <= fpc_d;
      tag_q <= tag_d;
    end
  end
  // a response with nothing outstanding means the memory broke the protocol
  assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && os_q == '0));
endmodule

// File: tb/tb_cpu6_ifu_fetch.sv
// tb_cpu6_ifu_fetch: randomized fetch traffic checked against a queue-level model
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
module tb_cpu6_ifu_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, reset, imem_req, imem_ready, imem_rvalid, redirect, stallD, validD;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instrD, pcD;
  cpu6_ifu_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stallD(stallD),
    .validD(validD), .instrD(instrD), .pcD(pcD)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic stale;} fl_t;
  typedef struct {logic [31:0] ins; logic [31:0] pc;} ent_t;
  typedef struct {logic [31:0] addr; int due;} mr_t;
  fl_t  inf[$];
  ent_t fq[$];
  mr_t  mq[$];
  logic [31:0] m_pc;
  logic m_known = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, k_lo = 1, k_hi = 1;
  logic rst_v = 1, stall_v = 0, redir_v = 0, ready_v = 1;
  logic [31:0] rpc_v = 0;
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic cycle();
    logic m_req, cons;
    fl_t e;
    mr_t r;
    @(negedge clk);
    reset = rst_v; stallD = stall_v; redirect = redir_v; redirect_pc = rpc_v; imem_ready = ready_v;
    imem_rvalid = !rst_v && mq.size() != 0 && mq[0].due <= cyc;
    imem_rdata = imem_rvalid ? memfn(mq[0].addr) : $urandom;
    #1;
    s_req = imem_req; s_valid = validD; s_addr = imem_addr; s_pc = pcD; s_instr = instrD;
    cons = fq.size() != 0 && !stall_v;
    m_req = !rst_v && !redir_v && (inf.size() + fq.size() - (cons ? 1 : 0) < DEPTH);
    if (m_known) begin
      chk("imem_req", {31'b0, s_req}, {31'b0, m_req});
      chk("validD", {31'b0, s_valid}, {31'b0, fq.size() != 0});
      if (!rst_v) chk("imem_addr", s_addr, m_pc);
      if (fq.size() != 0) begin
        chk("pcD", s_pc, fq[0].pc);
        chk("instrD", s_instr, fq[0].ins);
      end
    end
    if (rst_v) mq.delete();
    else begin
      if (imem_rvalid) void'(mq.pop_front());
      if (imem_req && imem_ready) begin
        r.addr = imem_addr;
        r.due = cyc + $urandom_range(k_hi, k_lo);
        if (mq.size() != 0 && r.due <= mq[$].due) r.due = mq[$].due + 1;
        mq.push_back(r);
      end
    end
    if (rst_v) begin
      m_pc = RPC; inf.delete(); fq.delete(); m_known = 1;
    end else if (redir_v) begin
      fq.delete();
      if (imem_rvalid && inf.size() != 0) void'(inf.pop_front());
      foreach (inf[i]) inf[i].stale = 1;
      m_pc = rpc_v;
    end else begin
      if (cons) void'(fq.pop_front());
      if (imem_rvalid && inf.size() != 0) begin
        e = inf.pop_front();
        if (!e.stale) fq.push_back('{memfn(e.pc), e.pc});
      end
      if (m_req && ready_v) begin
        inf.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 4;
      end
    end
    cyc++;
  endtask
  task automatic do_reset(int n);
    rst_v = 1; redir_v = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (i == n - 1) begin
        chk("rst_req", {31'b0, s_req}, 0);
        chk("rst_valid", {31'b0, s_valid}, 0);
        chk("rst_instr", s_instr, 0);
        chk("rst_pc", s_pc, 0);
      end
    end
    rst_v = 0;
  endtask
  task automatic wait_valid(string n, logic [31:0] exp);
    int b = 0;
    cycle();
    while (!s_valid && b < 40) begin cycle(); b++; end
    if (!s_valid) chk({n, "_timeout"}, 0, 1);
    else chk(n, s_pc, exp);
  endtask
  initial begin
    do_reset(3);
    cycle(); chk("c1_req", {31'b0, s_req}, 1); chk("c1_addr", s_addr, 32'h100);
    cycle(); cycle(); chk("c3_valid", {31'b0, s_valid}, 1); chk("c3_pc", s_pc, 32'h100);
    cycle(); chk("c4_pc", s_pc, 32'h104);
    cycle(); chk("c5_pc", s_pc, 32'h108); chk("c5_instr", s_instr, memfn(32'h108));
    repeat (20) cycle();
    do_reset(2);
    stall_v = 1;
    repeat (6) cycle();
    chk("bp_req", {31'b0, s_req}, 0); chk("bp_valid", {31'b0, s_valid}, 1); chk("bp_pc", s_pc, 32'h100);
    stall_v = 0;
    repeat (10) cycle();
    do_reset(2);
    k_lo = 3; k_hi = 3;
    cycle(); cycle();
    redir_v = 1; rpc_v = 32'h200;
    cycle(); chk("rd_req", {31'b0, s_req}, 0);
    redir_v = 0;
    cycle(); chk("rd1_valid", {31'b0, s_valid}, 0); chk("rd1_addr", s_addr, 32'h200);
    wait_valid("rd_first_pc", 32'h200);
    do_reset(2);
    cycle(); cycle(); cycle();
    redir_v = 1; rpc_v = 32'h300;
    cycle(); chk("rdv_rvalid", {31'b0, imem_rvalid}, 1);
    redir_v = 0;
    wait_valid("rdv_first_pc", 32'h300);
    do_reset(2);
    k_lo = 2; k_hi = 2; stall_v = 1;
    repeat (3) cycle();
    rst_v = 1; cycle(); rst_v = 0;
    cycle();
    chk("mr_valid", {31'b0, s_valid}, 0); chk("mr_addr", s_addr, RPC); chk("mr_req", {31'b0, s_req}, 1);
    stall_v = 0;
    for (int i = 0; i < 4000; i++) begin
      k_lo = 1; k_hi = $urandom_range(4, 1);
      stall_v = $urandom_range(99, 0) < 30;
      ready_v = $urandom_range(99, 0) < 75;
      redir_v = $urandom_range(99, 0) < 5;
      rpc_v = $urandom & 32'hFFFF_FFFC;
      rst_v = $urandom_range(299, 0) == 0;
      cycle();
    end
    rst_v = 0; redir_v = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
